// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I-cache/D-cache main-memory arbiter: RAM status,
// memory word and arbiter state encodings.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IGNT = 2'd1,
    ARB_DGNT = 2'd2
  } arb_state_t;

  // RAM signals completion only with ACCESS; FREE, BUSY and ERROR all keep waiting.
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache request ports and the single RAM port seen by the
// arbiter. The slave modport is the arbiter's view, master the environment's.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Instruction cache side
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  // Data cache side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data cache has priority, a saturating starvation
// counter forces an instruction grant after STARVE_MAX data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  localparam int CNT_W = $clog2(STARVE_MAX + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  mem_arbiter_if.slave     bus,
  output arb_state_t       o_state,
  output logic [CNT_W-1:0] o_starve_cnt
);

  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_starve_cnt;

  logic w_dreq;
  logic w_ireq;
  logic w_dack;
  logic w_iack;

  always_comb begin
    w_dreq = bus.dREN | bus.dWEN;
    w_ireq = bus.iREN;
    // A requester that drops its request forfeits the acknowledge even on ACCESS.
    w_dack = (r_state == ARB_DGNT) && w_dreq && ram_done(bus.ramstate);
    w_iack = (r_state == ARB_IGNT) && w_ireq && ram_done(bus.ramstate);
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    case (r_state)
      ARB_DGNT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        if (w_dack) begin
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
        end
      end
      ARB_IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (w_iack) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= ARB_IDLE;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_dreq && (!w_ireq || (r_starve_cnt < C_STARVE_MAX)))
            r_state <= ARB_DGNT;
          else if (w_ireq)
            r_state <= ARB_IGNT;
        end
        ARB_DGNT: begin
          if (!w_dreq) begin
            r_state <= ARB_IDLE;
          end else if (w_dack) begin
            r_state <= ARB_IDLE;
            // Only count data grants that actually made the instruction side wait.
            if (w_ireq) begin
              if (r_starve_cnt != C_STARVE_MAX)
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end else begin
              r_starve_cnt <= '0;
            end
          end
        end
        ARB_IGNT: begin
          if (!w_ireq) begin
            r_state <= ARB_IDLE;
          end else if (w_iack) begin
            r_state      <= ARB_IDLE;
            r_starve_cnt <= '0;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter, checked every cycle against
// an ownership/starvation reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int SMAX  = 4;
  localparam int CW    = $clog2(SMAX + 1);
  localparam int OWN_N = 0;
  localparam int OWN_I = 1;
  localparam int OWN_D = 2;

  logic          CLK;
  logic          nRST;
  arb_state_t    st;
  logic [CW-1:0] cnt;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .bus         (bus),
    .o_state     (st),
    .o_starve_cnt(cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who holds the RAM, and how many data grants the I-side has sat through.
  int m_owner  = OWN_N;
  int m_starve = 0;

  logic       last_iwait, last_dwait, last_ramREN, last_ramWEN;
  word_t      last_iload, last_dload, last_ramstore;
  arb_state_t last_state;
  logic [CW-1:0] last_cnt;
  string      order;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a falling edge; check mid-cycle, advance model, wait for next falling edge.
  task automatic step();
    logic dreq, ireq, done;
    logic e_ren, e_wen, e_iw, e_dw;
    word_t e_addr, e_store, e_il, e_dl;
    arb_state_t e_st;
    #1;
    if (!nRST) begin
      m_owner  = OWN_N;
      m_starve = 0;
    end
    dreq = bus.dREN | bus.dWEN;
    ireq = bus.iREN;
    done = (bus.ramstate == ACCESS);
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
    e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
    e_st = ARB_IDLE;
    if (m_owner == OWN_D) begin
      e_st    = ARB_DGNT;
      e_addr  = bus.daddr;
      e_store = bus.dstore;
      e_wen   = bus.dWEN;
      e_ren   = bus.dREN && !bus.dWEN;
      if (dreq && done) begin e_dw = 0; e_dl = bus.ramload; end
    end else if (m_owner == OWN_I) begin
      e_st   = ARB_IGNT;
      e_ren  = 1;
      e_addr = bus.iaddr;
      if (ireq && done) begin e_iw = 0; e_il = bus.ramload; end
    end
    chk("ramREN",   32'(bus.ramREN),   32'(e_ren));
    chk("ramWEN",   32'(bus.ramWEN),   32'(e_wen));
    chk("ramaddr",  bus.ramaddr,       e_addr);
    chk("ramstore", bus.ramstore,      e_store);
    chk("iwait",    32'(bus.iwait),    32'(e_iw));
    chk("dwait",    32'(bus.dwait),    32'(e_dw));
    chk("iload",    bus.iload,         e_il);
    chk("dload",    bus.dload,         e_dl);
    chk("state",    32'(st),           32'(e_st));
    chk("starve",   32'(cnt),          32'(m_starve));
    last_iwait = bus.iwait;  last_dwait = bus.dwait;
    last_iload = bus.iload;  last_dload = bus.dload;
    last_ramREN = bus.ramREN; last_ramWEN = bus.ramWEN;
    last_ramstore = bus.ramstore; last_state = st; last_cnt = cnt;
    if (nRST) begin
      if (m_owner == OWN_N) begin
        if (dreq && (!ireq || m_starve < SMAX)) m_owner = OWN_D;
        else if (ireq)                          m_owner = OWN_I;
      end else if (m_owner == OWN_D) begin
        if (!dreq) m_owner = OWN_N;
        else if (done) begin
          m_owner  = OWN_N;
          m_starve = ireq ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        end
      end else begin
        if (!ireq) m_owner = OWN_N;
        else if (done) begin m_owner = OWN_N; m_starve = 0; end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    int r;
    nRST = 0;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
    @(negedge CLK);
    step();
    chk("rst_state", 32'(last_state), 32'(ARB_IDLE));
    nRST = 1;
    step();

    // Instruction fetch, ACCESS on the second grant cycle
    bus.iREN = 1; bus.iaddr = 32'h100;
    step();
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h2408000A;
    step();
    chk("ifetch_iwait", 32'(last_iwait), 32'd0);
    chk("ifetch_iload", last_iload, 32'h2408000A);
    bus.iREN = 0; bus.ramstate = FREE;
    step();
    chk("ifetch_idle", 32'(last_state), 32'(ARB_IDLE));

    // Data write wins over simultaneous read
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h3F0; bus.dstore = 32'hDEADBEEF;
    bus.ramstate = BUSY;
    step();
    step();
    chk("dwr_ramWEN", 32'(last_ramWEN), 32'd1);
    chk("dwr_ramREN", 32'(last_ramREN), 32'd0);
    chk("dwr_store",  last_ramstore, 32'hDEADBEEF);
    bus.ramstate = ACCESS;
    step();
    chk("dwr_dwait", 32'(last_dwait), 32'd0);
    bus.dWEN = 0; bus.dREN = 0;
    step();

    // Dropped data request: no acknowledge, back to idle
    bus.dREN = 1; bus.ramstate = BUSY;
    step();
    bus.dREN = 0; bus.ramstate = ACCESS;
    step();
    chk("drop_dwait", 32'(last_dwait), 32'd1);
    step();

    // Starvation bound with both sides requesting continuously
    bus.iREN = 1; bus.dREN = 1; bus.ramstate = ACCESS;
    order = "";
    for (int k = 0; k < 20; k++) begin
      bus.ramload = $urandom;
      step();
      if (!last_dwait) order = {order, "D"};
      if (!last_iwait) order = {order, "I"};
    end
    n_cmp++;
    assert (order == "DDDDIDDDDI") else begin
      n_err++;
      $error("FAIL grant_order: observed %s expected DDDDIDDDDI", order);
    end

    // Reset in the middle of a data grant held by BUSY, with a non-zero counter
    step();
    step();
    bus.iREN = 0; bus.ramstate = BUSY;
    step();
    chk("pre_rst_cnt", 32'(last_cnt), 32'd1);
    nRST = 0;
    step();
    chk("mid_rst_state",  32'(last_state), 32'(ARB_IDLE));
    chk("mid_rst_ramREN", 32'(last_ramREN), 32'd0);
    chk("mid_rst_dwait",  32'(last_dwait), 32'd1);
    chk("mid_rst_cnt",    32'(last_cnt), 32'd0);
    bus.dREN = 0; nRST = 1;
    step();

    // ERROR holds the instruction grant until ACCESS
    bus.iREN = 1; bus.iaddr = 32'h2000; bus.ramstate = ERROR;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("err_iwait", 32'(last_iwait), 32'd1);
      chk("err_hold",  32'(last_state), 32'(ARB_IGNT));
    end
    bus.ramstate = ACCESS; bus.ramload = 32'h0BADF00D;
    step();
    chk("err_done_iwait", 32'(last_iwait), 32'd0);
    chk("err_done_iload", last_iload, 32'h0BADF00D);
    bus.iREN = 0;
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if (!last_iwait || $urandom_range(0, 15) == 0) begin
        bus.iREN  = 1'($urandom_range(0, 1));
        bus.iaddr = $urandom;
      end
      if (!last_dwait || $urandom_range(0, 15) == 0) begin
        r = int'($urandom_range(0, 3));
        bus.dREN   = r[0];
        bus.dWEN   = r[1];
        bus.daddr  = $urandom;
        bus.dstore = $urandom;
      end
      r = int'($urandom_range(0, 19));
      bus.ramstate = (r < 8) ? ACCESS : (r < 14) ? BUSY : (r < 17) ? FREE : ERROR;
      bus.ramload  = $urandom;
      nRST = (c == 700) ? 1'b0 : 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
